obj_blitter: RTL and testbench
==============================

Name: obj_blitter

Overview:
- Writer-side counterpart of the sprite display path: copies a width x height object from sprite memory into the frame memory at (posx, posy).
- Reads source pixels row-major from src_start_addr and writes them to the frame-memory write port.
- Throughput is one pixel per clock; pixels that fall outside the frame are clipped.
- Sits between the game logic, which issues start, and the frame memory that the VGA scan path reads.

Parameters:
- FB_WIDTH, 640, frame width in pixels.
- FB_HEIGHT, 480, frame height in pixels.
- SRC_ADDR_W, 18, sprite memory address width.
- FB_ADDR_W, 19, frame memory address width; must satisfy FB_WIDTH*FB_HEIGHT <= 2^FB_ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- posx  in  10  destination left column.
- posy  in  10  destination top row.
- width  in  10  object width in pixels.
- height  in  10  object height in pixels.
- src_start_addr  in  SRC_ADDR_W  sprite base address.
- color_key  in  12  transparent colour; used only with the optional feature.
- src_addr  out  SRC_ADDR_W  sprite memory read address (registered).
- src_data  in  12  sprite pixel; synchronous memory, valid one cycle after src_addr.
- fb_we  out  1  frame write enable.
- fb_addr  out  FB_ADDR_W  frame write address.
- fb_data  out  12  frame write data.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-copy aborts the copy:
  - fb_we goes low the cycle after rst is sampled.
  - done does not pulse.
  - No further writes are issued.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, latch posx, posy, width, height and src_start_addr; clear relx and rely.
  - If width==0 or height==0, go to DONE; otherwise go to RUN.
  - start in any other state is ignored; latched inputs are never altered mid-copy.
- RUN:
  - Each cycle, src_addr <= latched base + rely*width + relx. The sum is truncated to SRC_ADDR_W and wraps.
  - relx increments. At relx==width-1, relx <= 0 and rely increments.
  - After issuing pixel (width-1, height-1), go to DRAIN.
- Pipeline:
  - Read issued in cycle k; src_data valid in cycle k+1.
  - fb_we, fb_addr and fb_data are registered and appear in cycle k+2.
  - A two-stage valid/x/y shift register tracks each pixel through the pipeline.
- Addressing and clipping:
  - Destination x = posx+relx and y = posy+rely, computed in 11 bits (no wrap).
  - fb_addr = y*FB_WIDTH + x.
  - If x >= FB_WIDTH or y >= FB_HEIGHT, fb_we=0 for that pixel and the slot is still consumed.
- DRAIN: two cycles to empty the pipeline, then DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Timing, with start in cycle 0 and N = width*height:
  - busy=1 in cycles 1..N+2.
  - Pixel i is read in cycle 1+i and written in cycle 3+i.
  - done=1 in cycle N+3.
  - Zero-size copy: done=1 in cycle 1, busy never asserts.
- When fb_we=0, fb_addr and fb_data hold their last values.

Optional Feature:
- Macro: BLIT_COLORKEY_EN.
- When defined: a pixel whose src_data equals color_key is treated as clipped, so fb_we=0 in its write slot. Timing and done position are unchanged.
- When undefined: color_key is ignored and every in-frame pixel is written.

Test Plan:
- 2x2 at (0,0), base 100, sprite mem[100..103]=A,B,C,D -> writes (0,A),(640,C)... precisely addr/data pairs 0/A, 1/B, 640/C, 641/D in cycles 3-6; done in cycle 7; busy cycles 1-6.
- 4x1 at (638,10) -> only 2 writes, at addr 7038 and 7039; the two clipped slots have fb_we=0; done in cycle 7.
- width=0, height=5, start -> no fb_we; done in cycle 1; busy stays 0.
- 3x3 copy with start re-pulsed in cycle 4 -> second start ignored; exactly 9 write slots; single done in cycle 12.
- 8x8 copy with rst=1 in cycle 20 -> fb_we=0 from cycle 21; no done pulse; new start after reset produces correct first write 2 cycles after src_addr.
- BLIT_COLORKEY_EN, color_key=12'hF0F, 2x1 sprite {F0F, 123} at (5,5) -> single write, addr 3206 data 123; done in cycle 5.

Source files
------------

// File: rtl/obj_blitter.sv
// Object blitter: copies a width x height sprite into frame memory at (posx, posy), one pixel per clock.
// Optional BLIT_COLORKEY_EN: pixels equal to color_key are skipped.
module obj_blitter #(
   parameter int FB_WIDTH   = 640,
   parameter int FB_HEIGHT  = 480,
   parameter int SRC_ADDR_W = 18,
   parameter int FB_ADDR_W  = 19
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [9:0]            posx,
   input  logic [9:0]            posy,
   input  logic [9:0]            width,
   input  logic [9:0]            height,
   input  logic [SRC_ADDR_W-1:0] src_start_addr,
   input  logic [11:0]           color_key,
   output logic [SRC_ADDR_W-1:0] src_addr,
   input  logic [11:0]           src_data,
   output logic                  fb_we,
   output logic [FB_ADDR_W-1:0]  fb_addr,
   output logic [11:0]           fb_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [10:0]          FBW   = 11'(FB_WIDTH);
   localparam logic [10:0]          FBH   = 11'(FB_HEIGHT);
   localparam logic [FB_ADDR_W-1:0] FBW_A = FB_ADDR_W'(FB_WIDTH);

   state_t      state;
   logic [9:0]  px, py, w, h;
   logic [9:0]  relx, rely;
   logic        drain_cnt;
   logic        v1;
   logic [10:0] x1, y1;
   logic        last_pix;
   logic        wr;

   assign last_pix = (relx == w - 10'd1) && (rely == h - 10'd1);

`ifdef BLIT_COLORKEY_EN
   assign wr = v1 && (x1 < FBW) && (y1 < FBH) && (src_data != color_key);
`else
   logic unused_key;
   assign unused_key = ^color_key;
   assign wr = v1 && (x1 < FBW) && (y1 < FBH);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         px        <= '0;
         py        <= '0;
         w         <= '0;
         h         <= '0;
         relx      <= '0;
         rely      <= '0;
         drain_cnt <= 1'b0;
         v1        <= 1'b0;
         x1        <= '0;
         y1        <= '0;
         src_addr  <= '0;
         fb_we     <= 1'b0;
         fb_addr   <= '0;
         fb_data   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         v1   <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  px       <= posx;
                  py       <= posy;
                  w        <= width;
                  h        <= height;
                  relx     <= '0;
                  rely     <= '0;
                  src_addr <= src_start_addr;
                  if (width == 10'd0 || height == 10'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               v1 <= 1'b1;
               x1 <= {1'b0, px} + {1'b0, relx};
               y1 <= {1'b0, py} + {1'b0, rely};
               if (last_pix) begin
                  state     <= DRAIN;
                  drain_cnt <= 1'b0;
               end else begin
                  // Row-major scan of a contiguous sprite: base + rely*width + relx advances by one.
                  src_addr <= src_addr + SRC_ADDR_W'(1);
                  if (relx == w - 10'd1) begin
                     relx <= '0;
                     rely <= rely + 10'd1;
                  end else begin
                     relx <= relx + 10'd1;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase

         fb_we <= wr;
         if (wr) begin
            fb_addr <= FB_ADDR_W'(y1) * FBW_A + FB_ADDR_W'(x1);
            fb_data <= src_data;
         end
      end
   end

endmodule

// File: tb/tb_obj_blitter.sv
// Directed self-checking bench for obj_blitter: records outputs per cycle relative to start and
// compares against hand-computed schedules.
module tb_obj_blitter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  posx = '0, posy = '0, width = '0, height = '0;
   logic [17:0] src_start_addr = '0;
   logic [11:0] color_key = '0;
   logic [17:0] src_addr;
   logic [11:0] src_data;
   logic        fb_we;
   logic [18:0] fb_addr;
   logic [11:0] fb_data;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] mem [0:1023];

   logic        we_a   [0:99];
   logic [18:0] addr_a [0:99];
   logic [11:0] data_a [0:99];
   logic [17:0] sa_a   [0:99];
   logic        busy_a [0:99];
   logic        done_a [0:99];

   obj_blitter #(.FB_WIDTH(640), .FB_HEIGHT(480), .SRC_ADDR_W(18), .FB_ADDR_W(19)) dut (
      .clk(clk), .rst(rst), .start(start), .posx(posx), .posy(posy),
      .width(width), .height(height), .src_start_addr(src_start_addr),
      .color_key(color_key), .src_addr(src_addr), .src_data(src_data),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) src_data <= mem[src_addr[9:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rec(input int c);
      we_a[c]   = fb_we;
      addr_a[c] = fb_addr;
      data_a[c] = fb_data;
      sa_a[c]   = src_addr;
      busy_a[c] = busy;
      done_a[c] = done;
   endtask

   // Start pulsed in cycle 0; restart_c / rst_c give cycles in which start / rst are held high.
   task automatic run(input logic [9:0] x, input logic [9:0] y, input logic [9:0] wd,
                      input logic [9:0] ht, input logic [17:0] base, input int ncyc,
                      input int restart_c, input int rst_c);
      @(negedge clk);
      posx = x; posy = y; width = wd; height = ht; src_start_addr = base;
      start = 1'b1;
      rec(0);
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         rec(c);
         start = (c == restart_c);
         rst   = (c == rst_c);
         if (c == restart_c) posx = 10'd300;
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   int nw, nd;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[100] = 12'h0A1; mem[101] = 12'h0B2; mem[102] = 12'h0C3; mem[103] = 12'h0D4;
      mem[5]   = 12'h777;
      mem[200] = 12'hF0F; mem[201] = 12'h123;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_we", 32'(fb_we), 0);
      check("rst_srcaddr", 32'(src_addr), 0);
      check("rst_fbaddr", 32'(fb_addr), 0);
      check("rst_fbdata", 32'(fb_data), 0);
      rst = 1'b0;

      // 2x2 at (0,0), base 100
      run(10'd0, 10'd0, 10'd2, 10'd2, 18'd100, 9, -1, -1);
      check("t1_sa_c1", 32'(sa_a[1]), 100);
      for (int c = 1; c <= 9; c++) begin
         check($sformatf("t1_busy_c%0d", c), 32'(busy_a[c]), 32'(c >= 1 && c <= 6));
         check($sformatf("t1_done_c%0d", c), 32'(done_a[c]), 32'(c == 7));
         check($sformatf("t1_we_c%0d", c), 32'(we_a[c]), 32'(c >= 3 && c <= 6));
      end
      check("t1_addr_c3", 32'(addr_a[3]), 0);   check("t1_data_c3", 32'(data_a[3]), 32'h0A1);
      check("t1_addr_c4", 32'(addr_a[4]), 1);   check("t1_data_c4", 32'(data_a[4]), 32'h0B2);
      check("t1_addr_c5", 32'(addr_a[5]), 640); check("t1_data_c5", 32'(data_a[5]), 32'h0C3);
      check("t1_addr_c6", 32'(addr_a[6]), 641); check("t1_data_c6", 32'(data_a[6]), 32'h0D4);

      // 4x1 at (638,10): right two pixels clipped
      run(10'd638, 10'd10, 10'd4, 10'd1, 18'd0, 9, -1, -1);
      for (int c = 1; c <= 9; c++) begin
         check($sformatf("t2_we_c%0d", c), 32'(we_a[c]), 32'(c == 3 || c == 4));
         check($sformatf("t2_done_c%0d", c), 32'(done_a[c]), 32'(c == 7));
      end
      check("t2_addr_c3", 32'(addr_a[3]), 7038);
      check("t2_addr_c4", 32'(addr_a[4]), 7039);
      check("t2_addr_hold_c6", 32'(addr_a[6]), 7039);

      // zero-width copy
      run(10'd1, 10'd1, 10'd0, 10'd5, 18'd0, 5, -1, -1);
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("t3_busy_c%0d", c), 32'(busy_a[c]), 0);
         check($sformatf("t3_we_c%0d", c), 32'(we_a[c]), 0);
         check($sformatf("t3_done_c%0d", c), 32'(done_a[c]), 32'(c == 1));
      end

      // 3x3 at (1,1) with start re-pulsed in cycle 4
      run(10'd1, 10'd1, 10'd3, 10'd3, 18'd0, 16, 4, -1);
      nw = 0; nd = 0;
      for (int c = 0; c <= 16; c++) begin
         if (we_a[c]) nw++;
         if (done_a[c]) nd++;
      end
      check("t4_writes", 32'(nw), 9);
      check("t4_done_count", 32'(nd), 1);
      check("t4_done_c12", 32'(done_a[12]), 1);
      check("t4_addr_c3", 32'(addr_a[3]), 641);
      check("t4_addr_c11", 32'(addr_a[11]), 1923);

      // 8x8 with reset asserted in cycle 20
      run(10'd0, 10'd0, 10'd8, 10'd8, 18'd0, 40, -1, 20);
      check("t5_we_c20", 32'(we_a[20]), 1);
      nw = 0; nd = 0;
      for (int c = 21; c <= 40; c++) begin
         if (we_a[c] || busy_a[c]) nw++;
      end
      for (int c = 0; c <= 40; c++) if (done_a[c]) nd++;
      check("t5_we_busy_after_rst", 32'(nw), 0);
      check("t5_no_done", 32'(nd), 0);

      // fresh 1x1 copy after reset
      run(10'd2, 10'd3, 10'd1, 10'd1, 18'd5, 6, -1, -1);
      check("t6_sa_c1", 32'(sa_a[1]), 5);
      check("t6_we_c2", 32'(we_a[2]), 0);
      check("t6_we_c3", 32'(we_a[3]), 1);
      check("t6_addr_c3", 32'(addr_a[3]), 1922);
      check("t6_data_c3", 32'(data_a[3]), 32'h777);
      check("t6_done_c4", 32'(done_a[4]), 1);

      // 2x1 sprite {F0F,123} at (5,5) with color key F0F
      color_key = 12'hF0F;
      run(10'd5, 10'd5, 10'd2, 10'd1, 18'd200, 7, -1, -1);
      check("t7_done_c5", 32'(done_a[5]), 1);
      check("t7_we_c4", 32'(we_a[4]), 1);
      check("t7_addr_c4", 32'(addr_a[4]), 3206);
      check("t7_data_c4", 32'(data_a[4]), 32'h123);
`ifdef BLIT_COLORKEY_EN
      check("t7_we_c3", 32'(we_a[3]), 0);
`else
      check("t7_we_c3", 32'(we_a[3]), 1);
      check("t7_addr_c3", 32'(addr_a[3]), 3205);
      check("t7_data_c3", 32'(data_a[3]), 32'hF0F);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
